// File: rtl/screen_sequencer.sv
// Game-flow controller and VGA source selector for the breakout top level.
// Debounces the mode button, runs the MENU/PLAY/PAUSE/OVER/WIN flow, tracks the
// high score and switches the VGA source only on a vsync falling edge.
module screen_sequencer #(
  parameter int unsigned NUM_SRC         = 4,
  parameter int unsigned COLOR_W         = 4,
  parameter int unsigned SCORE_W         = 9,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_FRAMES     = 300
) (
  input  logic                           CLK,
  input  logic                           RST_BTN,
  input  logic                           BTNC,
  input  logic                           endgame,
  input  logic                           win_game,
  input  logic [SCORE_W-1:0]             curr_score,
  input  logic [NUM_SRC-1:0]             src_hs,
  input  logic [NUM_SRC-1:0]             src_vs,
  input  logic [NUM_SRC*3*COLOR_W-1:0]   src_rgb,
  output logic                           VGA_HS,
  output logic                           VGA_VS,
  output logic [COLOR_W-1:0]             VGA_R,
  output logic [COLOR_W-1:0]             VGA_G,
  output logic [COLOR_W-1:0]             VGA_B,
  output logic                           game_run,
  output logic                           game_rst,
  output logic [SCORE_W-1:0]             high_score,
  output logic [SCORE_W-1:0]             disp_score,
  output logic [2:0]                     state
);

  localparam int unsigned RGB_W = 3 * COLOR_W;
  localparam int unsigned SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned FR_W  = $clog2(HOLD_FRAMES + 1);

  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_OVER  = 3'd3,
    ST_WIN   = 3'd4
  } state_e;

  // Debouncer state
  logic             btn_meta_q;
  logic             btn_sync_q;
  logic             btn_stable_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic             db_flip_c;
  logic             press_c;

  // Flow state
  state_e           state_q;
  logic             game_rst_q;
  logic [SCORE_W-1:0] high_q;
  logic [FR_W-1:0]  frame_cnt_q;

  // Source selection
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] req_sel_c;
  logic [NUM_SRC-1:0] vs_prev_q;
  logic             mux_hs_c;
  logic             mux_vs_c;
  logic             mux_vs_prev_c;
  logic [RGB_W-1:0] mux_rgb_c;
  logic             boundary_c;

  // Output registers
  logic             vga_hs_q;
  logic             vga_vs_q;
  logic [RGB_W-1:0] vga_rgb_q;

  // Stable level flips on the last of DEBOUNCE_CYCLES consecutive mismatching cycles
  assign db_flip_c = (btn_sync_q != btn_stable_q) &&
                     (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
  assign press_c   = db_flip_c && btn_sync_q;

  // Two-flop synchroniser and debounce counter
  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      btn_stable_q <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      btn_meta_q <= BTNC;
      btn_sync_q <= btn_meta_q;
      if (btn_sync_q != btn_stable_q) begin
        if (db_flip_c) begin
          btn_stable_q <= btn_sync_q;
          db_cnt_q     <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  // Source index the current state asks for
  always_comb begin
    req_sel_c = '0;
    case (state_q)
      ST_MENU:           req_sel_c = SEL_W'(0);
      ST_PLAY, ST_PAUSE: req_sel_c = SEL_W'(1);
      ST_OVER:           req_sel_c = SEL_W'(2);
      ST_WIN:            req_sel_c = (NUM_SRC > 3) ? SEL_W'(3) : SEL_W'(2);
      default:           req_sel_c = '0;
    endcase
  end

  // Mux of the currently selected source; indices beyond NUM_SRC never match
  always_comb begin
    mux_hs_c      = 1'b1;
    mux_vs_c      = 1'b1;
    mux_vs_prev_c = 1'b1;
    mux_rgb_c     = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel_q == SEL_W'(i)) begin
        mux_hs_c      = src_hs[i];
        mux_vs_c      = src_vs[i];
        mux_vs_prev_c = vs_prev_q[i];
        mux_rgb_c     = src_rgb[i*RGB_W +: RGB_W];
      end
    end
  end

  assign boundary_c = mux_vs_prev_c && !mux_vs_c;

  // Selector only moves at a frame boundary of the source being shown
  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      sel_q     <= '0;
      vs_prev_q <= '1;
    end else begin
      vs_prev_q <= src_vs;
      if (boundary_c) begin
        sel_q <= req_sel_c;
      end
    end
  end

  // Registered VGA outputs, one cycle behind the selected source
  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      vga_hs_q  <= 1'b1;
      vga_vs_q  <= 1'b1;
      vga_rgb_q <= '0;
    end else begin
      vga_hs_q  <= mux_hs_c;
      vga_vs_q  <= mux_vs_c;
      vga_rgb_q <= mux_rgb_c;
    end
  end

  // Game-flow FSM, high score capture and end-screen frame counter
  always_ff @(posedge CLK) begin
    if (RST_BTN) begin
      state_q     <= ST_MENU;
      game_rst_q  <= 1'b0;
      high_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      game_rst_q <= 1'b0;
      case (state_q)
        ST_MENU: begin
          if (press_c) begin
            state_q    <= ST_PLAY;
            game_rst_q <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (endgame) begin
            state_q     <= win_game ? ST_WIN : ST_OVER;
            frame_cnt_q <= '0;
            if (curr_score > high_q) begin
              high_q <= curr_score;
            end
          end else if (press_c) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (press_c) begin
            state_q <= ST_PLAY;
          end
        end
        ST_OVER, ST_WIN: begin
          if (press_c) begin
            state_q <= ST_MENU;
          end else if (boundary_c) begin
            frame_cnt_q <= frame_cnt_q + FR_W'(1);
            if (frame_cnt_q == FR_W'(HOLD_FRAMES - 1)) begin
              state_q <= ST_MENU;
            end
          end
        end
        default: state_q <= ST_MENU;
      endcase
    end
  end

  assign VGA_HS     = vga_hs_q;
  assign VGA_VS     = vga_vs_q;
  assign VGA_R      = vga_rgb_q[RGB_W-1 -: COLOR_W];
  assign VGA_G      = vga_rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign VGA_B      = vga_rgb_q[COLOR_W-1:0];
  assign game_run   = (state_q == ST_PLAY);
  assign game_rst   = game_rst_q;
  assign high_score = high_q;
  assign disp_score = (state_q == ST_MENU) ? high_q : curr_score;
  assign state      = state_q;

endmodule
